// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Brief    : Shared AHB-Lite encodings and default-slave state type.
// Revision : 1.0  initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // NONSEQ and SEQ both have the upper htrans bit set.
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_addr_decoder_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_addr_decoder_mux_if
// Brief    : Master-side bus and packed slave-bank signals of the decoder/mux.
// Revision : 1.0  initial release
// ============================================================================
interface ahb_addr_decoder_mux_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic [ADDR_W-1:0]            haddr;
    logic [1:0]                   htrans;
    logic [NUM_SLAVES-1:0]        hsel;
    logic [NUM_SLAVES*DATA_W-1:0] slv_hrdata;
    logic [NUM_SLAVES-1:0]        slv_hreadyout;
    logic [NUM_SLAVES-1:0]        slv_hresp;
    logic [DATA_W-1:0]            hrdata;
    logic                         hready;
    logic                         hresp;
    logic                         decode_err;

    modport slave (
        input  haddr, htrans, slv_hrdata, slv_hreadyout, slv_hresp,
        output hsel, hrdata, hready, hresp, decode_err
    );

    modport master (
        output haddr, htrans, slv_hrdata, slv_hreadyout, slv_hresp,
        input  hsel, hrdata, hready, hresp, decode_err
    );
endinterface
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_default_slave
// Brief    : Answers unmapped active transfers with the two-cycle ERROR reply.
// Revision : 1.0  initial release
// ============================================================================
module ahb_default_slave
    import ahb_pkg::*;
(
    input  wire logic       hclk,
    input  wire logic       hreset,
    input  wire logic       sel,
    input  wire logic [1:0] htrans,
    input  wire logic       hready,
    output logic            hreadyout,
    output logic            hresp,
    output logic            decode_err
);

    ds_state_t r_state;
    logic      r_hreadyout;
    logic      r_hresp;
    logic      w_start;

    // ERR1 is itself a stall cycle, so only IDLE and ERR2 can accept a new error.
    assign w_start    = sel && is_active(htrans) && hready && (r_state != DS_ERR1);
    assign decode_err = w_start && !hreset;
    assign hreadyout  = r_hreadyout;
    assign hresp      = r_hresp;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= DS_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                DS_ERR1: begin
                    r_state     <= DS_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    if (w_start) begin
                        r_state     <= DS_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_ERROR;
                    end else begin
                        r_state     <= DS_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_addr_decoder_mux.sv
`default_nettype none
// ============================================================================
// Module   : ahb_addr_decoder_mux
// Brief    : Base/mask address decoder, data-phase owner tracking and response mux.
// Revision : 1.0  initial release
// ============================================================================
module ahb_addr_decoder_mux
    import ahb_pkg::*;
#(
    parameter int                           NUM_SLAVES = 4,
    parameter int                           ADDR_W     = 32,
    parameter int                           DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                          32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = {4{32'hF000_0000}}
) (
    input  wire logic             hclk,
    input  wire logic             hreset,
    ahb_addr_decoder_mux_if.slave bus
);

    localparam logic [NUM_SLAVES:0] C_DSEL_DEFAULT = {1'b1, {NUM_SLAVES{1'b0}}};

    logic [NUM_SLAVES-1:0] w_hsel;
    logic                  w_hit;
    logic [NUM_SLAVES:0]   r_dsel;
    logic [DATA_W-1:0]     w_hrdata;
    logic                  w_hready;
    logic                  w_hresp;
    logic                  w_ds_hreadyout;
    logic                  w_ds_hresp;
    logic                  w_decode_err;

    // Scanning upward and stopping at the first hit gives lowest-index priority.
    always_comb begin
        w_hsel = '0;
        w_hit  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!w_hit &&
                ((bus.haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                 (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
                w_hsel[i] = 1'b1;
                w_hit     = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_dsel <= C_DSEL_DEFAULT;
        end else if (w_hready) begin
            r_dsel <= {~w_hit, w_hsel};
        end
    end

    ahb_default_slave u_ds (
        .hclk       (hclk),
        .hreset     (hreset),
        .sel        (~w_hit),
        .htrans     (bus.htrans),
        .hready     (w_hready),
        .hreadyout  (w_ds_hreadyout),
        .hresp      (w_ds_hresp),
        .decode_err (w_decode_err)
    );

    always_comb begin
        w_hrdata = '0;
        w_hready = r_dsel[NUM_SLAVES] ? w_ds_hreadyout : 1'b1;
        w_hresp  = r_dsel[NUM_SLAVES] & w_ds_hresp;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_dsel[i]) begin
                w_hrdata = bus.slv_hrdata[i*DATA_W +: DATA_W];
                w_hready = bus.slv_hreadyout[i];
                w_hresp  = bus.slv_hresp[i];
            end
        end
    end

    assign bus.hsel       = w_hsel;
    assign bus.hrdata     = w_hrdata;
    assign bus.hready     = w_hready;
    assign bus.hresp      = w_hresp;
    assign bus.decode_err = w_decode_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_addr_decoder_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_addr_decoder_mux
// Brief    : Self-checking bench: directed scenarios plus a randomized model run.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_addr_decoder_mux;
    import ahb_pkg::*;

    logic hclk;
    logic hreset;
    int   n_checks;
    int   n_fail;

    ahb_addr_decoder_mux_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus ();
    ahb_addr_decoder_mux_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus_ov ();

    ahb_addr_decoder_mux dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    // Slave 1 has an all-zero mask and therefore matches every address.
    ahb_addr_decoder_mux #(
        .SLV_MASK ({32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000})
    ) dut_ov (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus_ov)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset            = 1'b1;
        bus.htrans        = HTRANS_IDLE;
        bus.slv_hreadyout = 4'b1111;
        bus.slv_hresp     = 4'b0000;
        bus.slv_hrdata    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        next_cycle();
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        hreset     = 1'b1;
        bus.haddr  = 32'h1000_0000;
        bus.htrans = HTRANS_NONSEQ;
        next_cycle();
        #2;
        n_checks++; if (bus.hsel !== 4'b0010) begin n_fail++; $display("FAIL reset_hsel got %b exp %b", bus.hsel, 4'b0010); end
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b100) begin n_fail++; $display("FAIL reset_rdy_rsp_err got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b100); end
        n_checks++; if (bus.hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got %h exp %h", bus.hrdata, 32'h0); end
        bus.haddr = 32'h8000_0000;
        #2;
        n_checks++; if ({bus.hsel, bus.decode_err} !== 5'b0) begin n_fail++; $display("FAIL reset_unmapped got %b exp %b", {bus.hsel, bus.decode_err}, 5'b0); end
        next_cycle();
        hreset = 1'b0;
    endtask

    task automatic test_decode();
        do_reset();
        bus.haddr  = 32'h2000_0040;
        bus.htrans = HTRANS_NONSEQ;
        #2;
        n_checks++; if (bus.hsel !== 4'b0100) begin n_fail++; $display("FAIL decode_hsel got %b exp %b", bus.hsel, 4'b0100); end
        next_cycle();
        bus.htrans = HTRANS_IDLE;
        #2;
        n_checks++; if (bus.hrdata !== 32'hCAFE_0002) begin n_fail++; $display("FAIL decode_hrdata got %h exp %h", bus.hrdata, 32'hCAFE_0002); end
        n_checks++; if ({bus.hready, bus.hresp} !== 2'b10) begin n_fail++; $display("FAIL decode_rdy_rsp got %b exp %b", {bus.hready, bus.hresp}, 2'b10); end
    endtask

    task automatic test_unmapped();
        do_reset();
        bus.haddr  = 32'h8000_0000;
        bus.htrans = HTRANS_NONSEQ;
        #2;
        n_checks++; if ({bus.hsel, bus.decode_err} !== 5'b0000_1) begin n_fail++; $display("FAIL unmapped_addr got %b exp %b", {bus.hsel, bus.decode_err}, 5'b0000_1); end
        next_cycle();
        bus.htrans = HTRANS_IDLE;
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b010) begin n_fail++; $display("FAIL unmapped_err1 got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b010); end
        next_cycle();
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b110) begin n_fail++; $display("FAIL unmapped_err2 got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b110); end
        next_cycle();
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.hrdata} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL unmapped_after got %b/%h exp 10/0", {bus.hready, bus.hresp}, bus.hrdata); end
    endtask

    task automatic test_wait_state();
        do_reset();
        bus.haddr  = 32'h1000_0000;
        bus.htrans = HTRANS_NONSEQ;
        next_cycle();
        bus.slv_hreadyout = 4'b1101;
        bus.haddr         = 32'h3000_0000;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_checks++; if (bus.hready !== 1'b0) begin n_fail++; $display("FAIL wait_hready[%0d] got %b exp 0", k, bus.hready); end
            n_checks++; if (bus.hrdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL wait_hrdata[%0d] got %h exp %h", k, bus.hrdata, 32'hCAFE_0001); end
            next_cycle();
        end
        bus.slv_hreadyout = 4'b1111;
        #2;
        n_checks++; if ({bus.hready, bus.hrdata} !== {1'b1, 32'hCAFE_0001}) begin n_fail++; $display("FAIL wait_release got %b/%h exp 1/%h", bus.hready, bus.hrdata, 32'hCAFE_0001); end
        next_cycle();
        bus.htrans = HTRANS_IDLE;
        #2;
        n_checks++; if (bus.hrdata !== 32'hCAFE_0003) begin n_fail++; $display("FAIL wait_new_owner got %h exp %h", bus.hrdata, 32'hCAFE_0003); end
    endtask

    task automatic test_idle_unmapped();
        do_reset();
        bus.haddr  = 32'hF000_0000;
        bus.htrans = HTRANS_IDLE;
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b100) begin n_fail++; $display("FAIL idle_unmapped got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b100); end
        bus.htrans = HTRANS_BUSY;
        next_cycle();
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b100) begin n_fail++; $display("FAIL busy_unmapped got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b100); end
        bus.htrans = HTRANS_IDLE;
    endtask

    task automatic test_overlap();
        bus_ov.htrans        = HTRANS_IDLE;
        bus_ov.slv_hreadyout = 4'b1111;
        bus_ov.slv_hresp     = 4'b0000;
        bus_ov.slv_hrdata    = '0;
        bus_ov.haddr         = 32'h0000_0010;
        #2;
        n_checks++; if (bus_ov.hsel !== 4'b0001) begin n_fail++; $display("FAIL overlap_low got %b exp %b", bus_ov.hsel, 4'b0001); end
        bus_ov.haddr = 32'h5000_0000;
        #2;
        n_checks++; if (bus_ov.hsel !== 4'b0010) begin n_fail++; $display("FAIL overlap_wild got %b exp %b", bus_ov.hsel, 4'b0010); end
        bus_ov.haddr = 32'h3000_0000;
        #2;
        n_checks++; if (bus_ov.hsel !== 4'b0010) begin n_fail++; $display("FAIL overlap_prio got %b exp %b", bus_ov.hsel, 4'b0010); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.haddr  = 32'h8000_0000;
        bus.htrans = HTRANS_NONSEQ;
        next_cycle();
        bus.haddr = 32'h9000_0000;
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b010) begin n_fail++; $display("FAIL b2b_err1a got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b010); end
        next_cycle();
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b111) begin n_fail++; $display("FAIL b2b_err2a got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b111); end
        next_cycle();
        bus.htrans = HTRANS_IDLE;
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b010) begin n_fail++; $display("FAIL b2b_err1b got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b010); end
        next_cycle();
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b110) begin n_fail++; $display("FAIL b2b_err2b got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b110); end
        next_cycle();
        #2;
        n_checks++; if ({bus.hready, bus.hresp} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle got %b exp %b", {bus.hready, bus.hresp}, 2'b10); end
    endtask

    task automatic test_mapped_after_error();
        do_reset();
        bus.haddr  = 32'h8000_0000;
        bus.htrans = HTRANS_NONSEQ;
        next_cycle();
        bus.haddr = 32'h0000_0100;
        next_cycle();
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err} !== 3'b110) begin n_fail++; $display("FAIL mae_err2 got %b exp %b", {bus.hready, bus.hresp, bus.decode_err}, 3'b110); end
        next_cycle();
        bus.htrans = HTRANS_IDLE;
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.hrdata} !== {2'b10, 32'hCAFE_0000}) begin n_fail++; $display("FAIL mae_owner got %b/%h exp 10/%h", {bus.hready, bus.hresp}, bus.hrdata, 32'hCAFE_0000); end
    endtask

    task automatic test_reset_during_error();
        do_reset();
        bus.haddr  = 32'h8000_0000;
        bus.htrans = HTRANS_NONSEQ;
        next_cycle();
        hreset     = 1'b1;
        bus.htrans = HTRANS_IDLE;
        #2;
        n_checks++; if ({bus.hready, bus.hresp} !== 2'b01) begin n_fail++; $display("FAIL rde_err1 got %b exp %b", {bus.hready, bus.hresp}, 2'b01); end
        next_cycle();
        hreset = 1'b0;
        #2;
        n_checks++; if ({bus.hready, bus.hresp, bus.decode_err, bus.hrdata} !== {3'b100, 32'h0}) begin n_fail++; $display("FAIL rde_out got %b/%h exp 100/0", {bus.hready, bus.hresp, bus.decode_err}, bus.hrdata); end
        n_checks++; if (dut.u_ds.r_state !== DS_IDLE) begin n_fail++; $display("FAIL rde_state got %0d exp %0d", dut.u_ds.r_state, DS_IDLE); end
    endtask

    // Reference: owner index 0..3 or 4 for the default slave; err_phase counts
    // the default slave's two ERROR cycles (0 none, 1 stall cycle, 2 final cycle).
    task automatic test_random(input int n);
        int          owner;
        int          err_phase;
        int          exp_idx;
        int          region;
        logic        rst;
        logic [3:0]  exp_hsel;
        logic [31:0] exp_rdata;
        logic        exp_rdy;
        logic        exp_rsp;
        logic        exp_derr;
        do_reset();
        owner     = 4;
        err_phase = 0;
        for (int c = 0; c < n; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            hreset     = rst;
            bus.haddr  = {4'($urandom_range(0, 15)), 28'($urandom)};
            bus.htrans = 2'($urandom_range(0, 3));
            bus.slv_hrdata = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                bus.slv_hreadyout[i] = ($urandom_range(0, 3) != 0);
                bus.slv_hresp[i]     = ($urandom_range(0, 7) == 0);
            end
            #2;
            region   = int'(bus.haddr >> 28);
            exp_idx  = (region < 4) ? region : 4;
            exp_hsel = (exp_idx < 4) ? 4'(1 << exp_idx) : 4'b0000;
            if (owner < 4) begin
                exp_rdata = bus.slv_hrdata[owner*32 +: 32];
                exp_rdy   = bus.slv_hreadyout[owner];
                exp_rsp   = bus.slv_hresp[owner];
            end else begin
                exp_rdata = 32'h0;
                exp_rdy   = (err_phase != 1);
                exp_rsp   = (err_phase != 0);
            end
            exp_derr = !rst && (exp_idx == 4) && (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ)
                       && exp_rdy && (err_phase != 1);
            n_checks++; if (bus.hsel !== exp_hsel) begin n_fail++; $display("FAIL rand_hsel c=%0d got %b exp %b", c, bus.hsel, exp_hsel); end
            n_checks++; if (bus.hrdata !== exp_rdata) begin n_fail++; $display("FAIL rand_hrdata c=%0d got %h exp %h", c, bus.hrdata, exp_rdata); end
            n_checks++; if ({bus.hready, bus.hresp} !== {exp_rdy, exp_rsp}) begin n_fail++; $display("FAIL rand_rdy_rsp c=%0d got %b exp %b", c, {bus.hready, bus.hresp}, {exp_rdy, exp_rsp}); end
            n_checks++; if (bus.decode_err !== exp_derr) begin n_fail++; $display("FAIL rand_decode_err c=%0d got %b exp %b", c, bus.decode_err, exp_derr); end
            if (rst) begin
                owner     = 4;
                err_phase = 0;
            end else begin
                err_phase = (err_phase == 1) ? 2 : (exp_derr ? 1 : 0);
                if (exp_rdy) owner = exp_idx;
            end
            next_cycle();
        end
        hreset     = 1'b0;
        bus.htrans = HTRANS_IDLE;
    endtask

    initial begin
        n_checks             = 0;
        n_fail               = 0;
        hreset               = 1'b1;
        bus.haddr            = '0;
        bus.htrans           = HTRANS_IDLE;
        bus.slv_hrdata       = '0;
        bus.slv_hreadyout    = 4'b1111;
        bus.slv_hresp        = 4'b0000;
        bus_ov.haddr         = '0;
        bus_ov.htrans        = HTRANS_IDLE;
        bus_ov.slv_hrdata    = '0;
        bus_ov.slv_hreadyout = 4'b1111;
        bus_ov.slv_hresp     = 4'b0000;
        #1;
        test_reset();
        test_decode();
        test_unmapped();
        test_wait_state();
        test_idle_unmapped();
        test_overlap();
        test_back_to_back();
        test_mapped_after_error();
        test_reset_during_error();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
